// File: rtl/dmem_arbiter_if.sv
// Bundle between the data-memory arbiter, its two requesters and the memory.
// Request handshake: rN_req rises with we/addr/size/wdata stable and holds until
// the cycle rN_gnt is seen high; the access is taken on that clock edge. rN_rsp_valid
// is a single-cycle pulse that qualifies rsp_rdata/rsp_err, with no back-pressure.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              r0_req;
  logic              r0_we;
  logic [ADDR_W+1:0] r0_addr;
  logic [1:0]        r0_size;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_gnt;
  logic              r0_rsp_valid;

  logic              r1_req;
  logic              r1_we;
  logic [ADDR_W+1:0] r1_addr;
  logic [1:0]        r1_size;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_gnt;
  logic              r1_rsp_valid;

  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              mem_load;
  logic              mem_store;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_size, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_size, r1_wdata,
    output r0_gnt, r0_rsp_valid, r1_gnt, r1_rsp_valid,
    output rsp_rdata, rsp_err,
    output mem_load, mem_store, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_size, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_size, r1_wdata,
    input  r0_gnt, r0_rsp_valid, r1_gnt, r1_rsp_valid,
    input  rsp_rdata, rsp_err,
    input  mem_load, mem_store, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for a single-port word memory:
// sub-word stores become read-modify-write, loads return zero-extended lanes.
module dmem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_arbiter_if.slave    bus,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2
  } state_t;

  state_t            state;
  logic              ptr;
  logic              lat_we;
  logic              lat_id;
  logic [ADDR_W-1:0] lat_word;
  logic [1:0]        lat_off;
  logic [1:0]        lat_size;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] merge_q;
  logic              rsp_valid0;
  logic              rsp_valid1;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic              gnt0;
  logic              gnt1;
  logic              req_we;
  logic [ADDR_W+1:0] req_addr;
  logic [1:0]        req_size;
  logic [DATA_W-1:0] req_wdata;
  logic              acc_err;
  logic              word_store;
  logic [4:0]        sh;
  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

  // With both requesting, ptr names the owner of this round (0 -> r0).
  assign gnt0 = (state == IDLE) && bus.r0_req && (!bus.r1_req || !ptr);
  assign gnt1 = (state == IDLE) && bus.r1_req && (!bus.r0_req ||  ptr);

  assign req_we    = gnt1 ? bus.r1_we    : bus.r0_we;
  assign req_addr  = gnt1 ? bus.r1_addr  : bus.r0_addr;
  assign req_size  = gnt1 ? bus.r1_size  : bus.r0_size;
  assign req_wdata = gnt1 ? bus.r1_wdata : bus.r0_wdata;

  assign acc_err = (lat_size == 2'b11) ||
                   ((lat_size == 2'b01) && lat_off[0]) ||
                   ((lat_size == 2'b10) && (lat_off != 2'b00));
  assign word_store = lat_we && (lat_size == 2'b10);

  assign sh        = {lat_off, 3'b000};
  assign lane      = (lat_size == 2'b00) ? DATA_W'(32'h0000_00FF) : DATA_W'(32'h0000_FFFF);
  assign lane_mask = lane << sh;
  assign load_data = (lat_size == 2'b10) ? bus.mem_rdata : ((bus.mem_rdata >> sh) & lane);
  assign merged    = (merge_q & ~lane_mask) | ((lat_wdata << sh) & lane_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      lat_we      <= 1'b0;
      lat_id      <= 1'b0;
      lat_word    <= '0;
      lat_off     <= '0;
      lat_size    <= '0;
      lat_wdata   <= '0;
      merge_q     <= '0;
      rsp_valid0  <= 1'b0;
      rsp_valid1  <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            lat_we    <= req_we;
            lat_id    <= gnt1;
            lat_word  <= req_addr[ADDR_W+1:2];
            lat_off   <= req_addr[1:0];
            lat_size  <= req_size;
            lat_wdata <= req_wdata;
            ptr       <= gnt0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (acc_err || !lat_we || word_store) begin
            rsp_valid0  <= !lat_id;
            rsp_valid1  <= lat_id;
            rsp_err_q   <= acc_err;
            rsp_rdata_q <= (acc_err || lat_we) ? '0 : load_data;
            state       <= IDLE;
          end else begin
            merge_q <= bus.mem_rdata;
            state   <= MERGE;
          end
        end
        MERGE: begin
          rsp_valid0  <= !lat_id;
          rsp_valid1  <= lat_id;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an asynchronous reset kills them at once.
  assign bus.mem_load  = (state == ACCESS) && !acc_err && !word_store;
  assign bus.mem_store = ((state == ACCESS) && !acc_err && word_store) || (state == MERGE);
  assign bus.mem_addr  = lat_word;
  assign bus.mem_wdata = (state == MERGE) ? merged : lat_wdata;

  assign bus.r0_gnt       = gnt0;
  assign bus.r1_gnt       = gnt1;
  assign bus.r0_rsp_valid = rsp_valid0;
  assign bus.r1_rsp_valid = rsp_valid1;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_err      = rsp_err_q;
  assign fsm_state        = state;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer for the single-port, word-organised data memory. It sits between the core load/store path (requester 0) and a secondary master such as a debug/DMA port (requester 1). It picks one request at a time round-robin and drives the memory's store/load/address/data strobes. Byte and halfword stores become read-modify-write sequences; loads are returned lane-extracted and zero-extended.

## Interface
- ADDR_W, 8, word-address width of the data memory (memory holds 2^ADDR_W 32-bit words)
- DATA_W, 32, memory word width (fixed at 32; sub-word lanes assume 4 bytes)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rN_req  in  1  request N (N = 0,1); must stay high with stable fields until rN_gnt
- rN_we  in  1  1 = store, 0 = load
- rN_addr  in  ADDR_W+2  byte address; [ADDR_W+1:2] = word index, [1:0] = byte offset
- rN_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- rN_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rN_gnt  out  1  one-cycle pulse: request N accepted this cycle
- rN_rsp_valid  out  1  one-cycle pulse: access for requester N complete
- rsp_rdata  out  32  load result, zero-extended; 0 for stores and errors
- rsp_err  out  1  qualifies rsp_valid: misaligned or illegal-size access
- mem_load  out  1  memory read strobe
- mem_store  out  1  memory write strobe (memory writes on the clk edge)
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, combinational from mem_addr

## Operation
- FSM states: IDLE, ACCESS, MERGE.
- IDLE: if any rN_req is high, grant one (rN_gnt combinational, same cycle), latch we/word/offset/size/wdata/id, and go to ACCESS. Otherwise stay in IDLE.
- Arbitration: round-robin with a 1-bit priority pointer. Reset value favours r0. After any grant, the pointer points at the other requester. With both requests high, the pointer owner wins and the loser waits with its request held.
- Error check in ACCESS: size 11, half at offset 1 or 3, or word at offset ≠ 0. On error there is no mem strobe; the response is err=1 with rdata=0, and the FSM returns to IDLE.
- ACCESS, load: mem_load=1. The selected lane of mem_rdata is shifted right by 8×offset and zero-extended, then registered into rsp_rdata. The FSM returns to IDLE.
- ACCESS, word store: mem_store=1 with mem_wdata=wdata. The FSM returns to IDLE.
- ACCESS, byte/half store: mem_load=1 and mem_rdata is captured into a merge register. The FSM goes to MERGE.
- MERGE: mem_store=1. mem_wdata is the merge register with the target byte or half lane at the offset replaced by wdata[7:0] or wdata[15:0]. The FSM returns to IDLE.
- The response is registered: rN_rsp_valid (for the latched id), rsp_err and rsp_rdata are set on the edge that leaves ACCESS (completing cases) or MERGE.
- mem_load and mem_store are decoded from the state and are never both high. mem_addr and mem_wdata are held from latched registers.
- No grant is issued outside IDLE. A request arriving mid-sequence waits.

## Timing
- Reset values: all gnt/rsp_valid 0, rsp_rdata 0, rsp_err 0, mem_load 0, mem_store 0, mem_addr 0, mem_wdata 0; FSM IDLE; pointer favours r0.
- Load, word store, error: gnt at cycle T, memory access at T+1, rsp_valid at T+2. The FSM is in IDLE at T+2, so a new grant is possible at T+2. Peak throughput is one access per 2 cycles.
- Sub-word store: gnt at T, read at T+1, write at T+2, rsp_valid at T+3. A new grant is possible at T+3.
- rsp_rdata and rsp_err hold their values until the next response.
- Reset asserted mid-sequence: immediate return to IDLE. The strobes drop asynchronously, so there is no partial MERGE write and no response is issued for the abandoned access.
- Deasserting rN_req before gnt is illegal; behaviour is undefined.

## Test plan
- Reset then idle: outputs at reset values, no strobes for 10 cycles.
- r0 word store 0xDEADBEEF to byte address 0x010, then r0 word load from 0x010. Required: mem_store at T+1 with mem_addr=0x04; rdata=0xDEADBEEF with r0_rsp_valid at T+2 of the load.
- Byte store 0xAA at byte address 0x013 over word 0x11223344. Required: read then write cycle; memory word 0xAA223344. Byte load from 0x013 returns 0x000000AA; half load from 0x012 returns 0x0000AA22.
- r0 and r1 both request continuously after reset. Required: grant order r0, r1, r0, r1; each gnt 2 cycles apart; rsp_valid on the matching id.
- Half load at offset 1, and word store at offset 2. Required: no mem strobe, rsp_err=1, rdata=0, memory unchanged.
- rst_n pulsed low during MERGE of a byte store. Required: no mem_store, FSM IDLE, no rsp_valid, target word unchanged.
